irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Parametrised interrupt front-end between external IRQ pins and the picoRV32 irq inputs of the SoC.
- Generalises the fixed irq_5/irq_6/irq_7 pins to NUM_IRQ channels.
- Each channel has a synchroniser, per-channel polarity, edge/level mode, sticky pending bit and enable mask.
- Configured and serviced through the iomem bus.

Parameters:
NUM_IRQ, 3, number of interrupt channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
BASE_ADDR, 32'h0300_0000, base of the 32-byte register window (aligned to 32 bytes)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
irq_in  in  NUM_IRQ  raw asynchronous interrupt pins
iomem_valid  in  1  bus request valid
iomem_ready  out  1  bus request accepted/completed
iomem_wstrb  in  4  byte write strobes; 0 = read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data, valid while iomem_ready=1
irq_out  out  NUM_IRQ  level interrupt requests to the CPU

Behaviour:
- Reset is asynchronous and active-low. While resetn=0:
  - iomem_ready=0, iomem_rdata=0, irq_out=0.
  - ENABLE=0, MODE=all 1 (edge), POLARITY=all 1 (active-low), PENDING=0.
  - Synchroniser and previous-sample flops = all 1 (idle-high pins).
- Resetting mid-transaction abandons the transaction: no ready is given and no register is written.
- Register map (offset from BASE_ADDR):
  - 0x00 ENABLE rw
  - 0x04 MODE rw (1=edge, 0=level)
  - 0x08 POLARITY rw (1=active-low)
  - 0x0C PENDING (read; write-1-to-clear)
  - 0x10 RAW ro (synchronised pins)
  - 0x14..0x1C reserved: read 0, writes ignored.
  - Bits >= NUM_IRQ read 0 and ignore writes.
- Bus handshake:
  - A request hits when iomem_valid=1 and addr[31:5]==BASE_ADDR[31:5].
  - iomem_ready pulses high for exactly one cycle, on the clock edge following a hit. It is 0 the cycle after, even if valid stays high.
  - A new hit is recognised only when ready=0, giving at most one access per 2 cycles.
  - Addresses outside the window: ready is never driven and rdata stays 0.
  - Write byte lane k is applied only when wstrb[k]=1.
  - rdata is registered with ready and returns to 0 when ready=0.
- Per channel i:
  - s = last synchroniser stage; p = s delayed one cycle.
  - active = s XOR POLARITY[i].
  - Edge mode event: active transition inactive->active, computed on raw samples (p != s and active). Changing POLARITY therefore never creates an event.
  - Edge mode: event sets PENDING[i] (sticky) until cleared by writing 1.
  - Level mode: PENDING[i] = active, registered every cycle; W1C has no lasting effect.
- Event and W1C on the same bit in the same cycle: set wins, pending stays 1.
- Masking: irq_out = PENDING & ENABLE, combinational from flops. Pending is held while masked and appears when enabled.
- Latency: pin edge -> PENDING/irq_out high after SYNC_STAGES+1 clock edges (3 at default). Write to ENABLE/PENDING -> irq_out changes on the same edge that raises iomem_ready.
- Input pulses shorter than one clock period may be lost. No requirement to catch them.

Decomposition:
- Package irq_ctrl_pkg:
  - register offsets OFF_ENABLE/OFF_MODE/OFF_POLARITY/OFF_PENDING/OFF_RAW
  - reset constants RST_MODE/RST_POLARITY
  - window width constant (5 address bits).
- Sub-module irq_chan_sync:
  - one channel: SYNC_STAGES synchroniser, previous-sample flop, polarity/edge-detect logic.
  - outputs s and event.
  - instantiated NUM_IRQ times by generate.
- Top level holds the bus decoder, register file, pending logic and output mask.

Test Plan:
1. Reset with all pins=1, then ENABLE write 0x7 -> no pending, irq_out=3'b000; RAW read returns 0x7.
2. Drive irq_in[1] 1->0 (default active-low edge) -> irq_out=3'b010 exactly 3 clocks later. Release pin -> irq_out stays 3'b010. Write 0x2 to PENDING -> irq_out=0 on the ready edge.
3. Set MODE=0x0, POLARITY=0x0, pins=0. Drive irq_in[2]=1 for 10 clocks -> irq_out[2] high for 10 clocks, delayed 3. Write 0x4 to PENDING mid-pulse -> irq_out[2] remains 1.
4. ENABLE=0 with edge on ch0 -> irq_out=0 and PENDING reads 0x1. Write ENABLE=0x1 -> irq_out=3'b001 on that ready edge. Force an event and W1C on the same cycle -> PENDING bit stays 1.
5. Bus checks:
   - Held iomem_valid read of 0x0300_0014 -> rdata=0, ready pulses every other cycle.
   - Access to 0x0300_0020 -> ready never asserts.
   - wstrb=4'b0010 write of 0xFFFF_FFFF to ENABLE -> ENABLE unchanged (NUM_IRQ=3).
6. Assert resetn=0 asynchronously mid-access with pending set -> irq_out, ready and PENDING clear immediately without a clock edge. NUM_IRQ=32 regression repeats scenario 2 on channel 31.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt front-end: register map, reset values and
// byte-lane handling for the iomem register window.
package irq_ctrl_pkg;

   localparam int unsigned WIN_BITS = 5;

   localparam logic [4:0] OFF_ENABLE   = 5'h00;
   localparam logic [4:0] OFF_MODE     = 5'h04;
   localparam logic [4:0] OFF_POLARITY = 5'h08;
   localparam logic [4:0] OFF_PENDING  = 5'h0C;
   localparam logic [4:0] OFF_RAW      = 5'h10;

   // Idle-high pins: edge mode, active-low by default.
   localparam logic [31:0] RST_MODE     = 32'hFFFF_FFFF;
   localparam logic [31:0] RST_POLARITY = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      RegEnable,
      RegMode,
      RegPolarity,
      RegPending,
      RegRaw,
      RegNone
   } reg_sel_e;

   function automatic reg_sel_e decode_reg(logic [2:0] word_idx);
      reg_sel_e sel;
      case (word_idx)
         OFF_ENABLE[4:2]:   sel = RegEnable;
         OFF_MODE[4:2]:     sel = RegMode;
         OFF_POLARITY[4:2]: sel = RegPolarity;
         OFF_PENDING[4:2]:  sel = RegPending;
         OFF_RAW[4:2]:      sel = RegRaw;
         default:           sel = RegNone;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] strb_mask(logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/irq_chan_sync.sv
// One interrupt channel: pin synchroniser, previous-sample flop and edge detector that
// reports an inactive->active transition of the synchronised pin.
module irq_chan_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_irq,
   input  logic i_polarity,
   output logic o_sync,
   output logic o_event
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_active;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync   = r_sync[SYNC_STAGES-1];
   assign w_active = o_sync ^ i_polarity;
   // Compare raw samples so a polarity change alone never looks like an edge.
   assign o_event  = (o_sync != r_prev) && w_active;

endmodule

// File: rtl/irq_ctrl.sv
// Parametrised interrupt front-end: per-channel sync/edge detect, sticky pending bits and an
// enable mask, configured over the iomem bus with a one-cycle ready pulse per access.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0300_0000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               iomem_valid,
   output logic               iomem_ready,
   input  logic [3:0]         iomem_wstrb,
   input  logic [31:0]        iomem_addr,
   input  logic [31:0]        iomem_wdata,
   output logic [31:0]        iomem_rdata,
   output logic [NUM_IRQ-1:0] irq_out
);

   logic [NUM_IRQ-1:0] r_enable, r_mode, r_polarity, r_pending;
   logic [NUM_IRQ-1:0] w_pending_d, w_sync, w_event, w_active, w_clr, w_wd, w_keep_n;
   logic               r_ready;
   logic [31:0]        r_rdata, w_rd_val, w_bmask, w_wd_m, w_keep;
   logic               w_hit, w_wr, w_unused;
   reg_sel_e           w_sel;

   for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
      irq_chan_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_chan (
         .clk       (clk),
         .resetn    (resetn),
         .i_irq     (irq_in[gi]),
         .i_polarity(r_polarity[gi]),
         .o_sync    (w_sync[gi]),
         .o_event   (w_event[gi])
      );
   end

   // Gating on !r_ready limits the bus to one access every two cycles.
   assign w_hit    = iomem_valid && !r_ready &&
                     (iomem_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
   assign w_wr     = w_hit && (iomem_wstrb != 4'b0000);
   assign w_sel    = decode_reg(iomem_addr[4:2]);
   assign w_bmask  = strb_mask(iomem_wstrb);
   assign w_wd_m   = iomem_wdata & w_bmask;
   assign w_keep   = ~w_bmask;
   assign w_wd     = w_wd_m[NUM_IRQ-1:0];
   assign w_keep_n = w_keep[NUM_IRQ-1:0];
   assign w_unused = ^{iomem_addr[1:0], w_wd_m, w_keep};

   assign w_active = w_sync ^ r_polarity;
   assign w_clr    = (w_wr && (w_sel == RegPending)) ? w_wd : '0;
   // Edge channels: set beats clear. Level channels simply follow the active level.
   assign w_pending_d = (r_mode & ((r_pending & ~w_clr) | w_event)) | (~r_mode & w_active);

   always_comb begin
      w_rd_val = '0;
      case (w_sel)
         RegEnable:   w_rd_val = 32'(r_enable);
         RegMode:     w_rd_val = 32'(r_mode);
         RegPolarity: w_rd_val = 32'(r_polarity);
         RegPending:  w_rd_val = 32'(r_pending);
         RegRaw:      w_rd_val = 32'(w_sync);
         default:     w_rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_enable   <= '0;
         r_mode     <= RST_MODE[NUM_IRQ-1:0];
         r_polarity <= RST_POLARITY[NUM_IRQ-1:0];
         r_pending  <= '0;
         r_ready    <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_ready   <= w_hit;
         r_rdata   <= (w_hit && (iomem_wstrb == 4'b0000)) ? w_rd_val : '0;
         r_pending <= w_pending_d;
         if (w_wr && (w_sel == RegEnable))   r_enable   <= (r_enable & w_keep_n) | w_wd;
         if (w_wr && (w_sel == RegMode))     r_mode     <= (r_mode & w_keep_n) | w_wd;
         if (w_wr && (w_sel == RegPolarity)) r_polarity <= (r_polarity & w_keep_n) | w_wd;
      end
   end

   assign iomem_ready = r_ready;
   assign iomem_rdata = r_rdata;
   assign irq_out     = r_pending & r_enable;

endmodule
